// File: rtl/if_id_pipe_stage.sv
// rtl/if_id_pipe_stage.sv - IF/ID pipeline stage with valid/ready handshake, flush, optional skid entry, stall counter
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       upstream (fetch) handshake
//   in_instr/in_pc          fetched instruction and its PC
//   flush                   kills every held entry and any same-cycle input
//   out_valid/out_ready     downstream (decode) handshake
//   out_instr/out_pc        instruction/PC to decode; out_instr is NOP_INSTR while out_valid=0
//   stall_cnt               saturating count of cycles with out_valid=1 and out_ready=0
module if_id_pipe_stage #(
   parameter int unsigned INSTR_W   = 32,
   parameter int unsigned PC_W      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int unsigned SKID      = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam logic [INSTR_W-1:0] NOP_VAL = INSTR_W'(NOP_INSTR);
   localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

   logic               main_valid_q, main_valid_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d;
   logic [PC_W-1:0]    main_pc_q,    main_pc_d;
   logic               skid_valid_q, skid_valid_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
   logic               in_ready_q,   in_ready_d;
   logic [CNT_W-1:0]   stall_cnt_q,  stall_cnt_d;

   logic in_fire;
   logic out_fire;

   // With the skid entry, in_ready is a flop so decode's out_ready never
   // reaches fetch combinationally. Without it, the single register can
   // accept whenever it is empty or being drained this cycle.
   generate
      if (SKID != 0) begin : g_reg_ready
         assign in_ready = in_ready_q;
      end else begin : g_comb_ready
         assign in_ready = !main_valid_q || out_ready;
      end
   endgenerate

   assign in_fire  = in_valid && in_ready;
   assign out_fire = main_valid_q && out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      stall_cnt_d  = stall_cnt_q;

      if (main_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end

      case ({main_valid_q, skid_valid_q})
         2'b00: begin
            if (in_fire) begin
               main_valid_d = 1'b1;
               main_instr_d = in_instr;
               main_pc_d    = in_pc;
            end
         end
         2'b10: begin
            if (in_fire && out_fire) begin
               main_instr_d = in_instr;
               main_pc_d    = in_pc;
            end else if (in_fire) begin
               // Only reachable with the skid entry; the combinational
               // in_ready blocks this case when SKID=0.
               if (SKID != 0) begin
                  skid_valid_d = 1'b1;
                  skid_instr_d = in_instr;
                  skid_pc_d    = in_pc;
               end
            end else if (out_fire) begin
               main_valid_d = 1'b0;
            end
         end
         default: begin
            // Both entries held: in_ready is low, so only a drain moves
            // the older skid entry forward.
            if (out_fire) begin
               main_valid_d = 1'b1;
               main_instr_d = skid_instr_q;
               main_pc_d    = skid_pc_q;
               skid_valid_d = 1'b0;
            end
         end
      endcase

      if (flush) begin
         main_valid_d = 1'b0;
         main_instr_d = NOP_VAL;
         main_pc_d    = '0;
         skid_valid_d = 1'b0;
         stall_cnt_d  = stall_cnt_q;
      end

      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         main_instr_q <= NOP_VAL;
         main_pc_q    <= '0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= NOP_VAL;
         skid_pc_q    <= '0;
         in_ready_q   <= 1'b1;
         stall_cnt_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_instr_q <= main_instr_d;
         main_pc_q    <= main_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         in_ready_q   <= in_ready_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign out_valid = main_valid_q;
   assign out_instr = main_valid_q ? main_instr_q : NOP_VAL;
   assign out_pc    = main_pc_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// tb/tb_if_id_pipe_stage.sv - scoreboard bench for if_id_pipe_stage (SKID=1/CNT_W=4 and SKID=0 instances)
module tb_if_id_pipe_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;

   logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
   logic [31:0] a_in_instr = '0, a_in_pc = '0, a_out_instr, a_out_pc;
   logic [3:0]  a_stall_cnt;

   logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
   logic [31:0] b_in_instr = '0, b_in_pc = '0, b_out_instr, b_out_pc;
   logic [15:0] b_stall_cnt;

   logic [63:0] a_q[$];
   logic [63:0] b_q[$];
   int          a_delivered = 0;
   int          b_delivered = 0;
   bit          started = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   if_id_pipe_stage #(.SKID(1), .CNT_W(4)) u_dut_a (
      .clock(clock), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_instr(a_in_instr), .in_pc(a_in_pc),
      .flush(flush),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_instr(a_out_instr), .out_pc(a_out_pc),
      .stall_cnt(a_stall_cnt)
   );

   if_id_pipe_stage #(.SKID(0), .CNT_W(16)) u_dut_b (
      .clock(clock), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_instr(b_in_instr), .in_pc(b_in_pc),
      .flush(1'b0),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_instr(b_out_instr), .out_pc(b_out_pc),
      .stall_cnt(b_stall_cnt)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return (pc << 8) | 32'h0000_0093;
   endfunction

   // Holds in_valid until the stage takes the item, then drops it.
   task automatic a_send(input logic [31:0] pc);
      int n;
      n = 0;
      a_in_valid = 1'b1;
      a_in_pc    = pc;
      a_in_instr = instr_of(pc);
      while (!a_in_ready && n < 50) begin
         tick();
         n++;
      end
      check_eq("a_send_accept", 64'(n < 50), 64'd1);
      tick();
      a_in_valid = 1'b0;
   endtask

   // Scoreboards: decisions taken at the falling edge reflect exactly what
   // the DUT sees at the following rising edge.
   always @(negedge clock) begin
      if (started) begin
         if (!a_out_valid) check_eq("a_nop_when_idle", a_out_instr, NOP);
         if (a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
               check_eq("a_out_extra_pc", a_out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               logic [63:0] e;
               e = a_q.pop_front();
               check_eq("a_out_pc", a_out_pc, e[31:0]);
               check_eq("a_out_instr", a_out_instr, e[63:32]);
               a_delivered++;
            end
         end
         if (reset || flush) a_q.delete();
         else if (a_in_valid && a_in_ready) a_q.push_back({a_in_instr, a_in_pc});
      end
   end

   always @(negedge clock) begin
      if (started) begin
         check_eq("b_in_ready_comb", b_in_ready, 64'(!b_out_valid || b_out_ready));
         if (!b_out_valid) check_eq("b_nop_when_idle", b_out_instr, NOP);
         if (b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
               check_eq("b_out_extra_pc", b_out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               logic [63:0] e;
               e = b_q.pop_front();
               check_eq("b_out_pc", b_out_pc, e[31:0]);
               check_eq("b_out_instr", b_out_instr, e[63:32]);
               b_delivered++;
            end
         end
         if (reset) b_q.delete();
         else if (b_in_valid && b_in_ready) b_q.push_back({b_in_instr, b_in_pc});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      int n;
      int sent;
      bit acc;

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      started = 1'b1;
      check_eq("rst_out_valid", a_out_valid, 64'd0);
      check_eq("rst_out_instr", a_out_instr, NOP);
      check_eq("rst_out_pc", a_out_pc, 64'd0);
      check_eq("rst_stall_cnt", a_stall_cnt, 64'd0);
      check_eq("rst_in_ready", a_in_ready, 64'd1);

      // Single transfer, one-cycle latency
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_instr  = 32'h0050_0093;
      a_in_pc     = 32'h100;
      tick();
      a_in_valid = 1'b0;
      check_eq("single_out_valid", a_out_valid, 64'd1);
      check_eq("single_out_instr", a_out_instr, 64'h0050_0093);
      check_eq("single_out_pc", a_out_pc, 64'h100);
      check_eq("single_in_ready", a_in_ready, 64'd1);
      tick();
      check_eq("drain_out_valid", a_out_valid, 64'd0);
      check_eq("drain_out_instr", a_out_instr, NOP);
      check_eq("drain_out_pc_hold", a_out_pc, 64'h100);

      // Backpressure into the skid entry, then release
      base = a_delivered;
      a_out_ready = 1'b0;
      a_send(32'h100);
      check_eq("ovf_in_ready_full", a_in_ready, 64'd1);
      a_send(32'h104);
      check_eq("ovf_in_ready_low", a_in_ready, 64'd0);
      check_eq("ovf_main_pc", a_out_pc, 64'h100);
      a_in_valid = 1'b1;
      a_in_pc    = 32'h108;
      a_in_instr = instr_of(32'h108);
      tick();
      check_eq("ovf_hold_in_ready", a_in_ready, 64'd0);
      check_eq("ovf_hold_main_pc", a_out_pc, 64'h100);
      a_out_ready = 1'b1;
      a_send(32'h108);
      n = 0;
      while (a_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      tick();
      check_eq("ovf_delivered", a_delivered - base, 64'd3);
      check_eq("ovf_empty_after", a_out_valid, 64'd0);

      // Flush while both entries are held
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a_out_ready = 1'b0;
      a_send(32'h300);
      a_send(32'h304);
      check_eq("fl_in_ready_low", a_in_ready, 64'd0);
      check_eq("fl_stall_before", a_stall_cnt, 64'd1);
      a_in_valid = 1'b1;
      a_in_pc    = 32'h200;
      a_in_instr = instr_of(32'h200);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      a_in_valid = 1'b0;
      check_eq("fl_out_valid", a_out_valid, 64'd0);
      check_eq("fl_out_instr", a_out_instr, 64'h0000_0013);
      check_eq("fl_out_pc", a_out_pc, 64'd0);
      check_eq("fl_in_ready", a_in_ready, 64'd1);
      check_eq("fl_stall_kept", a_stall_cnt, 64'd1);
      a_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check_eq("fl_nothing_out", a_out_valid, 64'd0);

      // Stall counter saturation at CNT_W=4
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a_out_ready = 1'b0;
      a_send(32'h400);
      for (int i = 0; i < 5; i++) tick();
      check_eq("sat_cnt_5", a_stall_cnt, 64'd5);
      for (int i = 0; i < 15; i++) tick();
      check_eq("sat_cnt_20", a_stall_cnt, 64'd15);
      tick();
      check_eq("sat_cnt_stays", a_stall_cnt, 64'd15);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("sat_cnt_reset", a_stall_cnt, 64'd0);

      // Reset and flush together while FULL
      a_send(32'h500);
      check_eq("rf_full", a_out_valid, 64'd1);
      reset = 1'b1;
      flush = 1'b1;
      a_in_valid = 1'b1;
      a_in_pc    = 32'h504;
      a_in_instr = instr_of(32'h504);
      tick();
      check_eq("rf_out_valid", a_out_valid, 64'd0);
      check_eq("rf_out_instr", a_out_instr, NOP);
      check_eq("rf_out_pc", a_out_pc, 64'd0);
      check_eq("rf_stall_cnt", a_stall_cnt, 64'd0);
      check_eq("rf_in_ready", a_in_ready, 64'd1);
      reset = 1'b0;
      flush = 1'b0;
      a_in_valid = 1'b0;
      tick();
      check_eq("rf_dropped", a_out_valid, 64'd0);
      a_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();

      // SKID=0: continuous stream with out_ready pattern 1,0,1
      sent = 0;
      for (int i = 0; i < 60 && sent < 8; i++) begin
         b_in_valid  = 1'b1;
         b_in_pc     = 32'h600 + 32'(4 * sent);
         b_in_instr  = instr_of(b_in_pc);
         b_out_ready = (i % 3) != 1;
         @(negedge clock);
         acc = b_in_ready;
         @(posedge clock);
         #1;
         if (acc) sent++;
      end
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      check_eq("b_all_sent", sent, 64'd8);
      n = 0;
      while (b_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      tick();
      check_eq("b_delivered", b_delivered, 64'd8);
      check_eq("b_empty_after", b_out_valid, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/if_id_pipe_stage.md
Name: if_id_pipe_stage

Overview:
- Parametrised IF/ID pipeline stage with a valid/ready handshake, flush support, an optional 2-entry skid buffer and a stall-cycle counter.
- Sits between the fetch unit (upstream) and decode (downstream).
- Carries instruction + PC. Bubbles are emitted as a configurable NOP encoding.
- Order-preserving; no data loss under backpressure.

Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 32, PC width in bits.
- NOP_INSTR, 32'h0000_0013, value driven on out_instr whenever out_valid=0 (truncated or zero-extended to INSTR_W).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  INSTR_W  fetched instruction.
- in_pc  in  PC_W  PC of fetched instruction.
- flush  in  1  synchronous kill of all held entries (branch mispredict).
- out_valid  out  1  out_instr/out_pc valid.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  INSTR_W  instruction to decode.
- out_pc  out  PC_W  PC to decode.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshake signals:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_valid and data must be held stable while in_valid=1 and in_ready=0. The block does not check this.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty.
- Reset (clock edge with reset=1):
  - out_valid=0, out_instr=NOP_INSTR, out_pc=0, stall_cnt=0.
  - Skid entry invalid; in_ready=1 from the next cycle.
  - Reset overrides every other input. Reset mid-transfer drops all held entries.
- Flush (reset=0, flush=1 at an edge):
  - Both entries are invalidated. out_valid=0, out_instr=NOP_INSTR, out_pc=0.
  - The same-cycle in_fire is discarded; flush has priority.
  - stall_cnt is unchanged.
  - in_ready=1 in the following cycle.
- SKID=1 state machine, on main/skid valid bits:
  - EMPTY (in_ready=1):
    - in_fire -> FULL, main<=in.
  - FULL (in_ready=1):
    - in_fire & out_fire -> FULL, main<=in.
    - in_fire & !out_fire -> OVERFLOW, skid<=in.
    - !in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - OVERFLOW (in_ready=0):
    - out_fire -> FULL, main<=skid.
    - otherwise hold.
  - in_ready is a register output with no combinational path from out_ready.
- SKID=0:
  - in_ready = !out_valid | out_ready, combinational.
  - Single register; OVERFLOW is unreachable.
- Outputs are driven from the main register only.
  - out_instr=NOP_INSTR whenever out_valid=0, including after a drain.
  - out_pc holds its last value when the register drains; 0 after reset or flush.
- stall_cnt:
  - +1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - Cleared only by reset.
- Ordering: FIFO order is preserved. The skid entry is always older than any later input.

Test Plan:
- Reset, then in_valid=1, instr=32'h00500093, pc=32'h100, out_ready=1 -> out_valid=1 next cycle with exactly those values; in_ready stays 1.
- SKID=1, out_ready=0, feed pc 0x100, 0x104, 0x108 back-to-back:
  - Main=0x100, skid=0x104; in_ready=0 on the cycle after 0x104 is accepted; 0x108 held upstream.
  - Release out_ready=1 -> outputs 0x100, 0x104, 0x108 in order, no loss or duplicate.
- Flush in OVERFLOW with in_valid=1 (pc 0x200) -> next cycle out_valid=0, out_instr=32'h00000013, out_pc=0, in_ready=1; 0x200 never appears at the output.
- CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15; reset -> 0.
- SKID=0, out_ready toggling 1,0,1 with a continuous input stream -> in_ready equals !out_valid|out_ready each cycle; all PCs delivered exactly once, in order.
- Reset asserted while FULL and flush=1 simultaneously -> reset values on all outputs; stall_cnt=0.
